mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 50 +++++
 rtl/mem_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of requester, memory and status signals shared by the arbiter
// and its environment. The slave view belongs to the arbiter. The master
// view belongs to the requesters and main memory that drive it.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 512
);
   // requester 0
   logic [ADDR_W-1:0] r0_addr;
   logic [31:0]       r0_wdata;
   logic              r0_rd_req;
   logic              r0_wr_req;
   logic [LINE_W-1:0] r0_rdata;
   logic              r0_ready;
   // requester 1
   logic [ADDR_W-1:0] r1_addr;
   logic [31:0]       r1_wdata;
   logic              r1_rd_req;
   logic              r1_wr_req;
   logic [LINE_W-1:0] r1_rdata;
   logic              r1_ready;
   // main memory
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_rd_req;
   logic              mem_wr_req;
   logic [LINE_W-1:0] mem_rdata;
   logic              mem_ready;
   // status
   logic [1:0]        grant;
   logic              timeout_err;

   modport slave (
      input  r0_addr, r0_wdata, r0_rd_req, r0_wr_req,
      input  r1_addr, r1_wdata, r1_rd_req, r1_wr_req,
      input  mem_rdata, mem_ready,
      output r0_rdata, r0_ready, r1_rdata, r1_ready,
      output mem_addr, mem_wdata, mem_rd_req, mem_wr_req,
      output grant, timeout_err
   );

   modport master (
      output r0_addr, r0_wdata, r0_rd_req, r0_wr_req,
      output r1_addr, r1_wdata, r1_rd_req, r1_wr_req,
      output mem_rdata, mem_ready,
      input  r0_rdata, r0_ready, r1_rdata, r1_ready,
      input  mem_addr, mem_wdata, mem_rd_req, mem_wr_req,
      input  grant, timeout_err
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single main-memory port.
// Only one transaction is outstanding at a time. The winner's address, data
// and operation are latched when it is granted. The memory side is driven
// from those latched copies, so requester inputs may change freely while a
// transaction is in flight. A wait that runs too long is aborted: the
// requester still gets its ready pulse, and a sticky error flag is set.
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int LINE_W  = 512,
   parameter int TIMEOUT = 64
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nx;

   // transaction context
   logic              owner;      // 0 = requester 0, 1 = requester 1
   logic              op_wr;      // latched operation of the owner
   logic              last;       // requester granted most recently
   logic [7:0]        cnt;        // cycles spent in WAIT

   // arbitration and control decode
   logic              req0;
   logic              req1;
   logic              any_req;
   logic              win;
   logic              win_wr;
   logic [ADDR_W-1:0] win_addr;
   logic [31:0]       win_wdata;
   logic [LINE_W-1:0] line_in;
   logic [7:0]        cnt_inc;
   logic              tmo_hit;
   logic              load;
   logic              done_ok;
   logic              done_tmo;
   logic              finish;

   // Pick the winner: on a tie, the requester not served last wins.
   // A write takes precedence over a read from the same requester.
   always_comb begin
      req0      = bus.r0_rd_req | bus.r0_wr_req;
      req1      = bus.r1_rd_req | bus.r1_wr_req;
      any_req   = req0 | req1;
      line_in   = bus.mem_rdata;
      win       = 1'b0;
      win_wr    = 1'b0;
      win_addr  = '0;
      win_wdata = 32'h0000_0000;
      if (req0 && req1) begin
         win = ~last;
      end else if (req1) begin
         win = 1'b1;
      end else begin
         win = 1'b0;
      end
      if (win) begin
         win_wr    = bus.r1_wr_req;
         win_addr  = bus.r1_addr;
         win_wdata = bus.r1_wdata;
      end else begin
         win_wr    = bus.r0_wr_req;
         win_addr  = bus.r0_addr;
         win_wdata = bus.r0_wdata;
      end
   end

   // Next-state logic and one-cycle control strobes for the datapath.
   always_comb begin
      state_nx = state;
      load     = 1'b0;
      done_ok  = 1'b0;
      done_tmo = 1'b0;
      finish   = 1'b0;
      cnt_inc  = cnt + 8'd1;
      tmo_hit  = (cnt_inc == TIMEOUT_CNT);
      case (state)
         IDLE: begin
            if (any_req) begin
               state_nx = ISSUE;
               load     = 1'b1;
            end else begin
               state_nx = IDLE;
            end
         end
         ISSUE: begin
            state_nx = WAIT;
         end
         WAIT: begin
            if (bus.mem_ready) begin
               state_nx = RESP;
               done_ok  = 1'b1;
            end else if (tmo_hit) begin
               state_nx = RESP;
               done_tmo = 1'b1;
            end else begin
               state_nx = WAIT;
            end
         end
         RESP: begin
            state_nx = IDLE;
            finish   = 1'b1;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Latch the winner's context on grant. Release the grant when the response completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner         <= 1'b0;
         op_wr         <= 1'b0;
         last          <= 1'b1;
         bus.grant     <= 2'b00;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= 32'h0000_0000;
      end else if (load) begin
         owner         <= win;
         op_wr         <= win_wr;
         bus.grant     <= win ? 2'b10 : 2'b01;
         bus.mem_addr  <= win_addr;
         bus.mem_wdata <= win_wdata;
      end else if (finish) begin
         bus.grant     <= 2'b00;
         last          <= owner;
      end
   end

   // Memory request pulses: high only during the ISSUE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.mem_rd_req <= 1'b0;
         bus.mem_wr_req <= 1'b0;
      end else begin
         bus.mem_rd_req <= load & ~win_wr;
         bus.mem_wr_req <= load & win_wr;
      end
   end

   // Wait-cycle counter: runs only in WAIT and restarts from zero otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= 8'd0;
      end else if (state == WAIT) begin
         cnt <= cnt_inc;
      end else begin
         cnt <= 8'd0;
      end
   end

   // Capture the returned line for the owner on a completed read only.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.r0_rdata <= '0;
         bus.r1_rdata <= '0;
      end else if (done_ok && !op_wr) begin
         if (owner) begin
            bus.r1_rdata <= line_in;
         end else begin
            bus.r0_rdata <= line_in;
         end
      end
   end

   // Completion pulse to the owner. It fires for both normal and aborted transactions.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.r0_ready <= 1'b0;
         bus.r1_ready <= 1'b0;
      end else begin
         bus.r0_ready <= (done_ok | done_tmo) & ~owner;
         bus.r1_ready <= (done_ok | done_tmo) & owner;
      end
   end

   // Sticky abort flag. Only reset clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.timeout_err <= 1'b0;
      end else if (done_tmo) begin
         bus.timeout_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter. The driver decides each
// transaction's winner from the arbitration rules and pushes the expected
// memory request and requester response. Independent monitors pop and
// compare these whenever the DUT issues a memory request or a ready pulse.
module tb_mem_arbiter;

   localparam int TIMEOUT = 64;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(32), .LINE_W(512)) bus ();

   mem_arbiter #(.ADDR_W(32), .LINE_W(512), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  grant;
   } mem_exp_t;

   typedef struct {
      int           d;      // cycles after ISSUE until mem_ready, <0 = never
      logic [511:0] line;
   } mem_rsp_t;

   typedef struct {
      int           who;
      logic [511:0] rd0;
      logic [511:0] rd1;
      bit           tmo;
      int           lat;    // ready cycle minus mem request cycle
      logic [31:0]  addr;
   } rsp_exp_t;

   mem_exp_t mem_q[$];
   mem_rsp_t rsp_q[$];
   rsp_exp_t exp_q[$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int issue_cyc = 0;

   // reference model of the arbiter as seen from outside
   bit           pend[2];
   bit           p_wr[2];
   logic [31:0]  p_addr[2];
   logic [31:0]  p_wdata[2];
   int           last_m;
   logic [511:0] rdata_m[2];
   bit           tmo_m;

   function automatic void check(string name, logic [511:0] got, logic [511:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endfunction

   function automatic logic [511:0] rand_line();
      logic [511:0] l;
      for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   function automatic logic ready_of(int w);
      return (w == 0) ? bus.r0_ready : bus.r1_ready;
   endfunction

   task automatic drive_req(int w, bit rd, bit wr, logic [31:0] a, logic [31:0] d);
      if (w == 0) begin
         bus.r0_rd_req = rd; bus.r0_wr_req = wr; bus.r0_addr = a; bus.r0_wdata = d;
      end else begin
         bus.r1_rd_req = rd; bus.r1_wr_req = wr; bus.r1_addr = a; bus.r1_wdata = d;
      end
   endtask

   task automatic drive_addr(int w, logic [31:0] a, logic [31:0] d);
      if (w == 0) begin
         bus.r0_addr = a; bus.r0_wdata = d;
      end else begin
         bus.r1_addr = a; bus.r1_wdata = d;
      end
   endtask

   task automatic raise(int w, bit rd, bit wr, logic [31:0] a, logic [31:0] d);
      pend[w]    = 1'b1;
      p_wr[w]    = wr;
      p_addr[w]  = a;
      p_wdata[w] = d;
      drive_req(w, rd, wr, a, d);
   endtask

   task automatic model_reset();
      pend[0] = 1'b0; pend[1] = 1'b0;
      last_m = 1;
      rdata_m[0] = '0; rdata_m[1] = '0;
      tmo_m = 1'b0;
   endtask

   // Resolve one transaction from the pending set. Push expectations.
   // Then wait for its ready pulse and drop the winner's request.
   task automatic serve(int d, logic [511:0] line);
      int w;
      bit got;
      mem_exp_t me;
      mem_rsp_t mr;
      rsp_exp_t re;
      if (pend[0] && pend[1]) w = 1 - last_m;
      else w = pend[0] ? 0 : 1;
      me.wr = p_wr[w]; me.addr = p_addr[w]; me.wdata = p_wdata[w];
      me.grant = (w == 0) ? 2'b01 : 2'b10;
      mem_q.push_back(me);
      mr.d = d; mr.line = line;
      rsp_q.push_back(mr);
      if (d < 0) tmo_m = 1'b1;
      else if (!p_wr[w]) rdata_m[w] = line;
      re.who = w; re.rd0 = rdata_m[0]; re.rd1 = rdata_m[1]; re.tmo = tmo_m;
      re.lat = (d < 0) ? TIMEOUT + 1 : d + 1;
      re.addr = p_addr[w];
      exp_q.push_back(re);
      last_m = w;
      got = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (ready_of(w)) begin
            got = 1'b1;
            break;
         end
         drive_addr(w, $urandom, $urandom);
      end
      check("ready_seen", got, 1'b1);
      drive_req(w, 1'b0, 1'b0, $urandom, $urandom);
      pend[w] = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic check_reset_values(string tag);
      check({tag, "_grant"}, bus.grant, 2'b00);
      check({tag, "_ready"}, {bus.r1_ready, bus.r0_ready}, 2'b00);
      check({tag, "_mem_req"}, {bus.mem_rd_req, bus.mem_wr_req}, 2'b00);
      check({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
      check({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
      check({tag, "_r0_rdata"}, bus.r0_rdata, 512'h0);
      check({tag, "_r1_rdata"}, bus.r1_rdata, 512'h0);
      check({tag, "_timeout_err"}, bus.timeout_err, 1'b0);
   endtask

   // cycle counter
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // memory-side monitor
   initial begin : mem_mon
      bit chk_low;
      mem_exp_t me;
      chk_low = 1'b0;
      forever begin
         @(negedge clk);
         if (chk_low) begin
            check("mem_req_one_cycle", {bus.mem_rd_req, bus.mem_wr_req}, 2'b00);
            chk_low = 1'b0;
         end
         if (bus.mem_rd_req || bus.mem_wr_req) begin
            if (mem_q.size() == 0) begin
               check("mem_req_unexpected", {bus.mem_rd_req, bus.mem_wr_req}, 2'b00);
            end else begin
               me = mem_q.pop_front();
               check("mem_op", {bus.mem_rd_req, bus.mem_wr_req}, me.wr ? 2'b01 : 2'b10);
               check("mem_addr", bus.mem_addr, me.addr);
               check("mem_wdata", bus.mem_wdata, me.wdata);
               check("grant_busy", bus.grant, me.grant);
               issue_cyc = cyc;
               chk_low = 1'b1;
            end
         end
      end
   end

   // main-memory responder
   initial begin : responder
      mem_rsp_t mr;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         if ((bus.mem_rd_req || bus.mem_wr_req) && rsp_q.size() != 0) begin
            mr = rsp_q.pop_front();
            if (mr.d >= 0) begin
               repeat (mr.d) @(posedge clk);
               #1;
               bus.mem_ready = 1'b1;
               bus.mem_rdata = mr.line;
               @(posedge clk); #1;
               // a stray pulse lands in RESP and must be ignored
               bus.mem_ready = ($urandom_range(0, 1) == 1);
               bus.mem_rdata = rand_line();
               @(posedge clk); #1;
               bus.mem_ready = 1'b0;
            end
         end
      end
   end

   // requester-side monitor
   initial begin : rsp_mon
      bit chk_idle;
      rsp_exp_t re;
      chk_idle = 1'b0;
      forever begin
         @(negedge clk);
         if (chk_idle) begin
            check("grant_idle", bus.grant, 2'b00);
            check("ready_one_cycle", {bus.r1_ready, bus.r0_ready}, 2'b00);
            chk_idle = 1'b0;
         end
         if (bus.r0_ready || bus.r1_ready) begin
            if (exp_q.size() == 0) begin
               check("ready_unexpected", {bus.r1_ready, bus.r0_ready}, 2'b00);
            end else begin
               re = exp_q.pop_front();
               check("ready_who", {bus.r1_ready, bus.r0_ready}, (re.who == 0) ? 2'b01 : 2'b10);
               check("r0_rdata", bus.r0_rdata, re.rd0);
               check("r1_rdata", bus.r1_rdata, re.rd1);
               check("timeout_err", bus.timeout_err, re.tmo);
               check("latency", cyc - issue_cyc, re.lat);
               check("mem_addr_hold", bus.mem_addr, re.addr);
               check("grant_resp", bus.grant, (re.who == 0) ? 2'b01 : 2'b10);
               chk_idle = 1'b1;
            end
         end
      end
   end

   // watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // stimulus
   initial begin
      int op;
      int d;
      bit got;
      mem_exp_t me;
      mem_rsp_t mr;
      rst = 1'b1;
      drive_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // simultaneous read and write right after reset: requester 0 first
      raise(0, 1'b1, 1'b0, 32'h0000_2000, 32'h0);
      raise(1, 1'b0, 1'b1, 32'h0000_3000, 32'hCAFE_BABE);
      serve(2, rand_line());
      serve(4, rand_line());

      // both requesters hold continuously: grants alternate
      raise(0, 1'b1, 1'b0, 32'h0000_5000, 32'h0);
      raise(1, 1'b1, 1'b0, 32'h0000_6000, 32'h0);
      for (int t = 0; t < 4; t++) begin
         serve($urandom_range(1, 6), rand_line());
         for (int w = 0; w < 2; w++)
            if (!pend[w]) raise(w, w == 0, w == 1, $urandom, $urandom);
      end
      while (pend[0] || pend[1]) serve(2, rand_line());

      // lone read, line 64 returned after 3 cycles
      raise(0, 1'b1, 1'b0, 32'h0000_1000, $urandom);
      serve(3, 512'd64);

      // read that never completes: aborted by the timeout
      raise(1, 1'b1, 1'b0, 32'h0000_7000, $urandom);
      serve(-1, 512'h0);
      repeat (4) begin
         @(posedge clk); #1;
         check("timeout_sticky", bus.timeout_err, 1'b1);
      end

      // reset in WAIT, then a late mem_ready: no completion anywhere
      drive_req(0, 1'b1, 1'b0, 32'h0000_4000, 32'h1234_5678);
      me.wr = 1'b0; me.addr = 32'h0000_4000; me.wdata = 32'h1234_5678; me.grant = 2'b01;
      mem_q.push_back(me);
      mr.d = 4; mr.line = rand_line();
      rsp_q.push_back(mr);
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (bus.mem_rd_req) begin
            got = 1'b1;
            break;
         end
      end
      check("abort_issue_seen", got, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      drive_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         check("abort_no_ready", {bus.r1_ready, bus.r0_ready}, 2'b00);
      end
      check_reset_values("abort");

      // randomized traffic
      for (int r = 0; r < 150; r++) begin
         if (!pend[0] && !pend[1])
            repeat ($urandom_range(0, 3)) begin
               @(posedge clk); #1;
            end
         for (int w = 0; w < 2; w++) begin
            if (!pend[w] && $urandom_range(0, 1) == 1) begin
               op = $urandom_range(0, 2);
               raise(w, op != 1, op != 0, $urandom, $urandom);
            end
         end
         if (!pend[0] && !pend[1]) raise($urandom_range(0, 1), 1'b1, 1'b0, $urandom, $urandom);
         d = ($urandom_range(0, 19) == 0) ? -1 : $urandom_range(1, 8);
         serve(d, rand_line());
      end
      while (pend[0] || pend[1]) serve(1, rand_line());

      repeat (5) @(posedge clk);
      #1;
      check("final_timeout_err", bus.timeout_err, tmo_m);
      check("mem_q_drained", mem_q.size(), 0);
      check("exp_q_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
